// File: rtl/ex_muldiv_sequencer.sv
// Iterative multiply / signed divide / signed remainder engine for the EX stage.
// Shift-add multiplier and restoring divider, one iteration per cycle over
// DATA_W cycles, followed by a sign-fix cycle and a single-cycle done pulse.
module ex_muldiv_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              isMul,
    input  logic              isDiv,
    input  logic              isMod,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_mul_q, is_mul_d;
    logic                is_div_q, is_div_d;
    logic                sgn1_q, sgn1_d;
    logic                sgn2_q, sgn2_d;
    logic                div0_q, div0_d;
    // a: multiplicand (mul) or dividend shifting out / quotient shifting in (div)
    logic [DATA_W-1:0]   a_q, a_d;
    // b: multiplier (mul) or divisor magnitude (div)
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                accept;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     trial;

    assign accept = (state_q == IDLE) && start && (isMul || isDiv || isMod) && !flush;
    assign busy   = (state_q == CALC) || (state_q == FIXUP);
    assign stall  = accept || busy;
    assign done   = (state_q == DONE);
    assign result = result_q;

    // Next-state, datapath iteration and sign fix-up.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        is_div_d = is_div_q;
        sgn1_d   = sgn1_q;
        sgn2_d   = sgn2_q;
        div0_d   = div0_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        rem_sh   = '0;
        trial    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CALC;
                    cnt_d    = CNT_W'(DATA_W - 1);
                    is_mul_d = isMul;
                    is_div_d = !isMul && isDiv;
                    sgn1_d   = op1[DATA_W-1];
                    sgn2_d   = op2[DATA_W-1];
                    div0_d   = (op2 == '0);
                    acc_d    = '0;
                    rem_d    = '0;
                    if (isMul) begin
                        a_d = op1;
                        b_d = op2;
                    end else begin
                        a_d = op1[DATA_W-1] ? -op1 : op1;
                        b_d = op2[DATA_W-1] ? -op2 : op2;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_mul_q) begin
                        if (b_q[0]) acc_d = acc_q + a_q;
                        a_d = a_q << 1;
                        b_d = b_q >> 1;
                    end else begin
                        rem_sh = {rem_q[DATA_W-1:0], a_q[DATA_W-1]};
                        trial  = rem_sh - {1'b0, b_q};
                        if (!trial[DATA_W]) begin
                            rem_d = trial;
                            a_d   = {a_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_d = rem_sh;
                            a_d   = {a_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (cnt_q == '0) state_d = FIXUP;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            FIXUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_mul_q) begin
                        result_d = acc_q;
                    end else if (is_div_q) begin
                        if (div0_q)              result_d = '1;
                        else if (sgn1_q ^ sgn2_q) result_d = -a_q;
                        else                      result_d = a_q;
                    end else begin
                        // With a zero divisor the remainder is |op1|; restoring
                        // the dividend sign yields op1 itself, so no special case.
                        result_d = sgn1_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            is_div_q <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            is_div_q <= is_div_d;
            sgn1_q   <= sgn1_d;
            sgn2_q   <= sgn2_d;
            div0_q   <= div0_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: expected results are queued at
// accept time and popped when done pulses.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        isMul = 1'b0;
    logic        isDiv = 1'b0;
    logic        isMod = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy, stall, done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    ex_muldiv_sequencer #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .isMul  (isMul),
        .isDiv  (isDiv),
        .isMod  (isMod),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // op: 0 mul, 1 div, 2 mod, 3 mul+div flags together
    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        sa  = int'(a);
        sbv = int'(b);
        case (op)
            0, 3: return a * b;
            1: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sbv);
            end
            default: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sbv);
            end
        endcase
    endfunction

    task automatic accept(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input bit push);
        @(posedge clk); #1;
        start = 1'b1;
        isMul = (op == 0) || (op == 3);
        isDiv = (op == 1) || (op == 3);
        isMod = (op == 2);
        op1 = a;
        op2 = b;
        @(negedge clk);
        check("accept_stall", {31'b0, stall}, 32'd1);
        if (push) exp_q.push_back(expv);
        @(posedge clk); #1;
        start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
        op1 = $urandom; op2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int poke_at);
        int k = 0;
        int bad = 0;
        bit seen = 1'b0;
        logic [31:0] expv;
        while (!seen && k < 40) begin
            if (poke_at > 0 && k + 1 == poke_at) begin
                @(posedge clk); #1;
                start = 1'b1; isDiv = 1'b1; op1 = 32'd50; op2 = 32'd5;
            end
            if (poke_at > 0 && k == poke_at) begin
                @(posedge clk); #1;
                start = 1'b0; isDiv = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_stall_at_done"}, {31'b0, stall}, 32'd0);
            end else if (stall !== 1'b1 || busy !== 1'b1) begin
                bad++;
            end
        end
        check({tag, "_latency"}, seen ? 32'(k) : 32'd0, 32'd34);
        check({tag, "_stall_window"}, 32'(bad), 32'd0);
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            expv = exp_q.pop_front();
            if (seen) check({tag, "_result"}, result, expv);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int dcount;
        logic [31:0] ra, rb;
        int rop;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   {31'b0, busy},  32'd0);
        check("rst_stall",  {31'b0, stall}, 32'd0);
        check("rst_done",   {31'b0, done},  32'd0);
        check("rst_result", result,         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic operations
        accept(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        wait_done("mul_7_m3", 0);
        accept(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        wait_done("div_m7_2", 0);
        accept(2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        wait_done("mod_m7_2", 0);
        accept(1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_5_0", 0);
        accept(2, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_done("mod_5_0", 0);
        accept(2, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 1'b1);
        wait_done("mod_m10_0", 0);
        accept(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done("div_min_m1", 0);
        accept(2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        wait_done("mod_min_m1", 0);
        accept(3, 32'd6, 32'd7, 32'd42, 1'b1);
        wait_done("prio_mul", 0);

        // start with no op flag is ignored
        @(posedge clk); #1; start = 1'b1;
        @(negedge clk); check("noop_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check("noop_busy", {31'b0, busy}, 32'd0);

        // flush in IDLE suppresses start
        @(posedge clk); #1; start = 1'b1; isMul = 1'b1; flush = 1'b1;
        @(negedge clk); check("idleflush_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1; start = 1'b0; isMul = 1'b0; flush = 1'b0;
        @(negedge clk); check("idleflush_busy", {31'b0, busy}, 32'd0);

        // start while busy is ignored; exactly one done
        accept(0, 32'd9, 32'd11, 32'd99, 1'b1);
        wait_done("busy_start", 5);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("busy_start_no_second_done", 32'(dcount), 32'd0);

        // flush mid-CALC aborts, result kept; fresh start at T+12 accepted
        accept(1, 32'd100, 32'd7, 32'd0, 1'b0);
        dcount = 0;
        repeat (9) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        check("flush_busy_t10", {31'b0, busy}, 32'd1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        if (done === 1'b1) dcount++;
        check("flush_busy_t11",  {31'b0, busy},  32'd0);
        check("flush_stall_t11", {31'b0, stall}, 32'd0);
        check("flush_no_done",   32'(dcount),    32'd0);
        check("flush_result",    result,         32'd99);
        accept(2, 32'd100, 32'd7, 32'd2, 1'b1);
        wait_done("after_flush_mod", 0);

        // reset mid-CALC
        accept(0, 32'h1234, 32'h5678, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'b0, busy},  32'd0);
        check("midrst_stall",  {31'b0, stall}, 32'd0);
        check("midrst_done",   {31'b0, done},  32'd0);
        check("midrst_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(0, 32'd3, 32'd4, 32'd12, 1'b1);
        wait_done("mul_3_4", 0);

        // signed mixes and random operands through the reference model
        accept(1, 32'hFFFF_FF9C, 32'd7, model(1, 32'hFFFF_FF9C, 32'd7), 1'b1);
        wait_done("div_m100_7", 0);
        accept(2, 32'd100, 32'hFFFF_FFF9, model(2, 32'd100, 32'hFFFF_FFF9), 1'b1);
        wait_done("mod_100_m7", 0);
        accept(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, model(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9), 1'b1);
        wait_done("div_m100_m7", 0);
        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : ($urandom >> 20);
            rop = $urandom_range(0, 2);
            accept(rop, ra, rb, model(rop, ra, rb), 1'b1);
            wait_done("random", 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
